// File: rtl/audio_pkg.sv
// Shared constants, helper function and state type for the microphone capture path.
package audio_pkg;

  localparam int unsigned DefaultDecim = 64;
  localparam int unsigned DefaultPcmW  = 16;
  localparam int unsigned CicOrder     = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN
  } cic_state_e;

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC differentiator: output is the input minus its value at the previous decimated tick.
module cic_comb_stage #(
  parameter int unsigned Width = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o
);

  logic [Width-1:0] delay_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      delay_q <= '0;
    end else if (tick_i) begin
      delay_q <= din_i;
    end
  end

  assign dout_o = din_i - delay_q;

endmodule

// File: rtl/pdm_cic_decimator.sv
// 3rd-order CIC decimator turning the 1-bit mic PDM stream into signed PCM words,
// delivered over a valid/ready handshake with a sticky overrun flag.
module pdm_cic_decimator
  import audio_pkg::*;
#(
  parameter int unsigned DECIM = DefaultDecim,
  parameter int unsigned PCM_W = DefaultPcmW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pdm_ce,
  input  logic             pdm_bit,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun
);

  localparam int unsigned CntW  = log2_ceil(DECIM);
  localparam int unsigned ACC_W = CicOrder * CntW + 2;

  // Integrators and decimation counter
  logic [ACC_W-1:0] in_val;
  logic [ACC_W-1:0] int1_q, int2_q, int3_q;
  logic [ACC_W-1:0] int1_d, int2_d, int3_d;
  logic [CntW-1:0]  cnt_q;
  logic             cnt_last;
  logic             dec_tick_q;

  assign in_val   = pdm_bit ? ACC_W'(1) : {ACC_W{1'b1}};
  assign cnt_last = (cnt_q == CntW'(DECIM - 1));

  // Unpipelined chain so the DECIM-th bit lands in int3 on the same edge.
  assign int1_d = int1_q + in_val;
  assign int2_d = int2_q + int1_d;
  assign int3_d = int3_q + int2_d;

  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      int1_q     <= '0;
      int2_q     <= '0;
      int3_q     <= '0;
      cnt_q      <= '0;
      dec_tick_q <= 1'b0;
    end else begin
      dec_tick_q <= pdm_ce && cnt_last;
      if (pdm_ce) begin
        int1_q <= int1_d;
        int2_q <= int2_d;
        int3_q <= int3_d;
        cnt_q  <= cnt_last ? '0 : cnt_q + CntW'(1);
      end
    end
  end

  // Comb chain, evaluated in the cycle dec_tick_q is high
  logic [ACC_W-1:0] comb1, comb2, comb3;

  cic_comb_stage #(
    .Width (ACC_W)
  ) u_comb1 (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (!en),
    .tick_i  (dec_tick_q),
    .din_i   (int3_q),
    .dout_o  (comb1)
  );

  cic_comb_stage #(
    .Width (ACC_W)
  ) u_comb2 (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (!en),
    .tick_i  (dec_tick_q),
    .din_i   (comb1),
    .dout_o  (comb2)
  );

  cic_comb_stage #(
    .Width (ACC_W)
  ) u_comb3 (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (!en),
    .tick_i  (dec_tick_q),
    .din_i   (comb2),
    .dout_o  (comb3)
  );

  // Scaling: take the PCM_W bits just below the sign; +DECIM^3 is the only value that overflows.
  logic [ACC_W+PCM_W-1:0] comb_wide;
  logic [PCM_W-1:0]       sample;
  logic                   unused_bits;

  assign comb_wide   = {comb3, {PCM_W{1'b0}}};
  assign unused_bits = ^{comb_wide[ACC_W+PCM_W-1], comb_wide[ACC_W-2:0]};

  always_comb begin
    sample = comb_wide[ACC_W+PCM_W-2 -: PCM_W];
    if (!comb3[ACC_W-1] && comb3[ACC_W-2]) begin
      sample = {1'b0, {(PCM_W-1){1'b1}}};
    end
  end

  // Control FSM: the first three comb outputs are transients and are discarded
  cic_state_e state_q, state_d;
  logic [1:0] settle_q, settle_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (!en) begin
      state_d  = IDLE;
      settle_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SETTLE;
        end
        SETTLE: begin
          if (dec_tick_q) begin
            if (settle_q == 2'd2) begin
              state_d  = RUN;
              settle_d = '0;
            end else begin
              settle_d = settle_q + 2'd1;
            end
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output handshake
  logic             load;
  logic [PCM_W-1:0] pcm_data_q, pcm_data_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic             overrun_q, overrun_d;

  assign load = (state_q == RUN) && dec_tick_q;

  always_comb begin
    pcm_data_d  = pcm_data_q;
    pcm_valid_d = pcm_valid_q;
    overrun_d   = overrun_q;
    if (load) begin
      if (pcm_valid_q && !pcm_ready) begin
        overrun_d = 1'b1;
      end else begin
        pcm_data_d  = sample;
        pcm_valid_d = 1'b1;
      end
    end else if (pcm_valid_q && pcm_ready) begin
      pcm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pcm_data  = pcm_data_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator: pattern table, handshake corner cases and
// randomized PDM checked against a direct convolution model of the CIC response.
module tb_pdm_cic_decimator;

  localparam int D       = 64;
  localparam int HLen    = 3 * D - 2;
  localparam int Full    = D * D * D;
  localparam int MaxBits = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        pdm_ce;
  logic        pdm_bit;
  logic        pcm_ready;
  logic [15:0] pcm_data;
  logic        pcm_valid;
  logic        overrun;

  pdm_cic_decimator #(
    .DECIM (D),
    .PCM_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .pdm_ce    (pdm_ce),
    .pdm_bit   (pdm_bit),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int          h [HLen];
  bit          hist [MaxBits];
  int          nbits;
  int          n256_cyc;
  int          first_valid_cyc;
  bit          rand_ready;
  logic [15:0] got_q [$];

  // Transfers happen at the next posedge when valid && ready are seen here.
  always @(negedge clk) begin
    if (pcm_valid && pcm_ready) got_q.push_back(pcm_data);
    if (pcm_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) pcm_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic strobe(input bit b, input int gap);
    pdm_ce  = 1'b1;
    pdm_bit = b;
    tick();
    if (en && nbits < MaxBits) begin
      hist[nbits] = b;
      nbits++;
      if (nbits == 4 * D) n256_cyc = cyc;
    end
    pdm_ce = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic clear_model();
    got_q.delete();
    nbits           = 0;
    n256_cyc        = -1;
    first_valid_cyc = -1;
  endtask

  task automatic restart(input bit ready);
    en         = 1'b0;
    pdm_ce     = 1'b0;
    rand_ready = 1'b0;
    pcm_ready  = ready;
    tick();
    tick();
    clear_model();
    en = 1'b1;
  endtask

  function automatic bit pat_bit(input int pattern, input int i);
    case (pattern)
      0:       return 1'b1;
      1:       return 1'b0;
      default: return (i % 2) == 0;
    endcase
  endfunction

  // Decimated output m (1-based) = causal convolution of +/-1 inputs with box^3.
  function automatic int ref_cic(input int m);
    int n;
    int y;
    n = m * D - 1;
    y = 0;
    for (int k = 0; k < HLen; k++) begin
      if (n - k >= 0) y += h[k] * (hist[n-k] ? 1 : -1);
    end
    return y;
  endfunction

  function automatic logic [15:0] ref_pcm(input int y);
    int s;
    if (y >= Full) return 16'h7fff;
    s = y >>> 3;
    return s[15:0];
  endfunction

  typedef struct {
    string       name;
    int          pattern;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [3];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int          bias;
    logic [15:0] exp5;

    for (int k = 0; k < HLen; k++) h[k] = 0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        for (int l = 0; l < D; l++) h[i+j+l]++;

    vecs[0] = '{name: "ones",  pattern: 0, exp: 16'h7fff};
    vecs[1] = '{name: "zeros", pattern: 1, exp: 16'h8000};
    vecs[2] = '{name: "alt",   pattern: 2, exp: 16'h0000};

    reset      = 1'b0;
    en         = 1'b0;
    pdm_ce     = 1'b0;
    pdm_bit    = 1'b0;
    pcm_ready  = 1'b1;
    rand_ready = 1'b0;
    clear_model();

    // Reset state
    repeat (3) tick();
    check("reset_valid", 32'(pcm_valid), 32'd0);
    check("reset_data", 32'(pcm_data), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    tick();

    // Constant and alternating patterns, consumer always ready
    for (int v = 0; v < 3; v++) begin
      restart(1'b1);
      for (int i = 0; i < 8 * D; i++) strobe(pat_bit(vecs[v].pattern, i), 2);
      repeat (4) tick();
      check({vecs[v].name, "_count"}, 32'(got_q.size()), 32'd5);
      check({vecs[v].name, "_first_valid"}, 32'(first_valid_cyc), 32'(n256_cyc + 1));
      for (int i = 0; i < got_q.size(); i++)
        check({vecs[v].name, "_sample"}, 32'(got_q[i]), 32'(vecs[v].exp));
    end

    // Back-pressure across two ticks: data frozen, overrun sticky until en drops
    restart(1'b0);
    for (int i = 0; i < 4 * D; i++) strobe(1'b1, 2);
    check("bp_first_valid", 32'(pcm_valid), 32'd1);
    check("bp_first_data", 32'(pcm_data), 32'h7fff);
    check("bp_no_overrun_yet", 32'(overrun), 32'd0);
    for (int i = 0; i < D; i++) strobe(1'b0, 2);
    check("bp_frozen_data", 32'(pcm_data), 32'h7fff);
    check("bp_still_valid", 32'(pcm_valid), 32'd1);
    check("bp_overrun_set", 32'(overrun), 32'd1);
    pcm_ready = 1'b1;
    tick();
    check("bp_valid_after_xfer", 32'(pcm_valid), 32'd0);
    check("bp_overrun_sticky", 32'(overrun), 32'd1);
    check("bp_xfer_count", 32'(got_q.size()), 32'd1);
    check("bp_xfer_data", 32'(got_q.size() > 0 ? got_q[0] : 16'hdead), 32'h7fff);
    repeat (5) tick();
    check("bp_overrun_held", 32'(overrun), 32'd1);
    en = 1'b0;
    tick();
    check("bp_en_low_overrun", 32'(overrun), 32'd0);
    check("bp_en_low_data", 32'(pcm_data), 32'd0);

    // Ready rises exactly on the cycle a new sample loads
    restart(1'b0);
    for (int i = 0; i < 4 * D; i++) strobe(1'b1, 2);
    for (int i = 0; i < D - 1; i++) strobe(1'b0, 2);
    pdm_ce  = 1'b1;
    pdm_bit = 1'b0;
    tick();
    hist[nbits] = 1'b0;
    nbits++;
    pdm_ce    = 1'b0;
    pcm_ready = 1'b1;
    exp5      = ref_pcm(ref_cic(5));
    tick();
    check("same_cycle_valid", 32'(pcm_valid), 32'd1);
    check("same_cycle_overrun", 32'(overrun), 32'd0);
    check("same_cycle_data", 32'(pcm_data), 32'(exp5));
    check("same_cycle_xfer", 32'(got_q.size() > 0 ? got_q[0] : 16'hdead), 32'h7fff);

    // Reset mid-decimation, then full settle on restart
    restart(1'b1);
    for (int i = 0; i < 4 * D + 30; i++) strobe(1'b1, 2);
    reset = 1'b0;
    tick();
    check("midrst_valid", 32'(pcm_valid), 32'd0);
    check("midrst_data", 32'(pcm_data), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    clear_model();
    for (int i = 0; i < 4 * D + 2; i++) strobe(1'b1, 2);
    repeat (2) tick();
    check("midrst_restart_first_valid", 32'(first_valid_cyc), 32'(n256_cyc + 1));

    // en low mid-decimation, then full settle on restart
    for (int i = 0; i < 20; i++) strobe(1'b1, 2);
    en = 1'b0;
    tick();
    check("miden_valid", 32'(pcm_valid), 32'd0);
    check("miden_data", 32'(pcm_data), 32'd0);
    restart(1'b1);
    for (int i = 0; i < 4 * D + 2; i++) strobe(1'b1, 2);
    repeat (2) tick();
    check("miden_restart_first_valid", 32'(first_valid_cyc), 32'(n256_cyc + 1));

    // Randomized PDM density, strobe spacing and consumer readiness
    restart(1'b1);
    rand_ready = 1'b1;
    for (int blk = 0; blk < 16; blk++) begin
      bias = int'($urandom_range(0, 100));
      for (int i = 0; i < D; i++)
        strobe(int'($urandom_range(0, 99)) < bias, int'($urandom_range(2, 4)));
    end
    repeat (20) tick();
    rand_ready = 1'b0;
    pcm_ready  = 1'b1;
    tick();
    check("rand_count", 32'(got_q.size()), 32'd13);
    for (int i = 0; i < got_q.size() && i < 13; i++)
      check("rand_sample", 32'(got_q[i]), 32'(ref_pcm(ref_cic(i + 4))));
    check("rand_overrun", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Converts the 1-bit PDM stream from the MEMS microphone into 16-bit signed PCM samples with a 3rd-order CIC decimator. It sits between the microphone pins (`micDataPDM`, sampled on `micGenCLK` edges) and the recording FSM / BRAM write path. It hands out one PCM word per `DECIM` mic bits over a valid/ready handshake. Single clock domain (`big_clk`). The mic clock rate is conveyed by a one-cycle strobe, not a second clock.

## Interface
- `DECIM`, 64: decimation ratio. Power of two, 16..256.
- `PCM_W`, 16: output sample width.
- `ACC_W`, 3*log2(`DECIM`)+2: integrator/comb width. Derived; not overridden.
- `clk`  in  1: system clock (`big_clk`).
- `reset`  in  1: synchronous, active-low reset.
- `en`  in  1: capture enable (debounced `recordEN`). Level.
- `pdm_ce`  in  1: one-`clk` strobe marking a valid `pdm_bit` (mic clock edge).
- `pdm_bit`  in  1: microphone data bit.
- `pcm_data`  out  `PCM_W`: signed PCM sample.
- `pcm_valid`  out  1: `pcm_data` holds an untransferred sample.
- `pcm_ready`  in  1: consumer accepts `pcm_data` this cycle.
- `overrun`  out  1: sticky. A sample was dropped because the previous one was still pending.

## Operation
- **Input mapping:** `pdm_bit`=1 maps to +1 and 0 maps to −1, sign-extended to `ACC_W`.
- **Integrators:**
  - 3 cascaded `ACC_W` two's-complement accumulators.
  - They update only on `pdm_ce`=1 with `en`=1.
  - Wrap-around is modular by design; no saturation inside the filter.
- **Decimation counter:**
  - Runs 0..`DECIM`−1, advancing on each qualifying `pdm_ce`.
  - At `DECIM`−1 with `pdm_ce`, it wraps to 0 and raises an internal `dec_tick` for one cycle.
- **Combs:**
  - 3 cascaded differentiators (delay 1 at the decimated rate), clocked by `dec_tick`.
  - Output = comb3 result.
- **Scaling:**
  - `pcm_data` = comb3[`ACC_W`−2 -: `PCM_W`].
  - Exactly +`DECIM`^3 saturates to 0x7FFF.
  - −`DECIM`^3 yields 0x8000 naturally.
- **State machine:**
  - IDLE: `en`=0. Integrators, combs, counter, settle count and `pcm_valid` are cleared; `pcm_data`=0.
  - IDLE→SETTLE when `en`=1.
  - SETTLE: the filter runs, but the first 3 comb outputs are discarded (comb delays not yet primed). SETTLE→RUN on the 3rd `dec_tick`.
  - RUN: every `dec_tick` produces a sample.
  - Any state→IDLE when `en`=0; takes effect next edge and discards a pending sample.
- **Handshake:**
  - Transfer occurs when `pcm_valid` && `pcm_ready`. `pcm_valid` drops the next cycle unless a new sample is loaded that same cycle; load wins.
  - While `pcm_valid` && !`pcm_ready`, `pcm_data` is frozen.
  - A new sample arriving while `pcm_valid` && !`pcm_ready` is dropped and `overrun` is set. Transfer and the arrival of a new sample on the same cycle is not an overrun.
  - `overrun` clears only on reset or in IDLE.
- **Reset:**
  - `reset`=0 at a `clk` edge forces IDLE.
  - All registers go to 0; `pcm_valid`=0, `overrun`=0, `pcm_data`=0.
  - Mid-sample reset discards partial accumulations.

## Timing
- `pdm_ce` at edge N completing the `DECIM`-th bit: integrators register at N, combs and `pcm_data` register at N+1, `pcm_valid`=1 after N+1. Latency is 2 `clk`.
- Throughput: one sample per `DECIM` `pdm_ce` strobes. `pdm_ce` is at most one per 2 `clk`.
- First valid sample after `en` rises: 4·`DECIM` strobes + 2 `clk`.
- `pcm_ready` is sampled at the edge. There is no combinational path from `pcm_ready` to any output.
- `en` falling: `pcm_valid`=0 from the next edge.

## Structure
- **Shared package** (`audio_pkg`):
  - `DECIM` default, `PCM_W`.
  - Log2 function for `ACC_W`.
  - State enum {IDLE, SETTLE, RUN}.
- **Sub-module:** `cic_comb_stage` (one differentiator with a `dec_tick` enable), instantiated 3 times.
- Integrators, counter, FSM and handshake stay in the top.

## Test plan
- All-ones PDM, `pcm_ready`=1:
  - After settle, every sample = 0x7FFF.
  - The first `pcm_valid` appears exactly 4·64 strobes + 2 `clk` after `en`.
- All-zeros PDM → every sample = 0x8000.
- Alternating 1/0 → every sample after settle = 0x0000.
- Hold `pcm_ready`=0 across two `dec_tick`s:
  - `pcm_data` stays at the first sample.
  - `overrun`=1 after the second tick.
  - Raise `pcm_ready` → one transfer; `overrun` stays 1 until `en`=0.
- `pcm_ready` asserted on the same cycle a new sample loads → `pcm_valid` remains 1 with the new data, and `overrun`=0.
- `reset`=0 (or `en`=0) mid-decimation:
  - All outputs are 0 next edge.
  - On restart, the full settle period is repeated before any `pcm_valid`.
